yarvis_alu_arbiter: RTL and testbench

Shares the single W-bit adder/subtractor datapath in the yarvis core between NREQ requesters using round-robin arbitration. Each requester presents operands and an opcode with a valid/ready handshake. The block runs one operation at a time through a three-state sequencer and returns a tagged result with backpressure. It sits between the core's operand sources (decoder, address generator, etc.) and the shared adder.

---
 rtl/yarvis_alu_arbiter_pkg.sv | 15 +
 rtl/yarvis_alu_arbiter_if.sv | 30 +++
 rtl/yarvis_alu_arbiter_rr_pick.sv | 27 ++
 rtl/yarvis_alu_arbiter.sv | 110 +++++++++++
 tb/tb_yarvis_alu_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/yarvis_alu_arbiter_pkg.sv
// Shared definitions for the yarvis ALU arbiter: sequencer states, opcodes and default widths.
package yarvis_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int W_DEF    = 8;
  localparam int NREQ_DEF = 4;
  localparam int IDW_DEF  = 2;
endpackage

// File: rtl/yarvis_alu_arbiter_if.sv
// Request/response bundle between the operand sources and the shared adder arbiter.
interface yarvis_alu_arbiter_if
  import yarvis_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = IDW_DEF
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_op;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_carry;
  logic              busy;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, busy
  );
endinterface

// File: rtl/yarvis_alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at NREQ-1.
module yarvis_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);
  always_comb begin
    any = 1'b0;
    gnt = '0;
    idx = '0;
    // Outer loop walks priority distance from ptr; inner loop keeps indices constant.
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!any && req[i] && (((int'(ptr) + k) % NREQ) == i)) begin
          any    = 1'b1;
          gnt[i] = 1'b1;
          idx    = IDW'(i);
        end
      end
    end
  end
endmodule

// File: rtl/yarvis_alu_arbiter.sv
// Round-robin arbiter sharing one W-bit add/sub datapath between NREQ requesters.
module yarvis_alu_arbiter
  import yarvis_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = IDW_DEF
) (
  input logic                 clk,
  input logic                 rst,
  yarvis_alu_arbiter_if.slave bus
);
  function automatic logic [W:0] add_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic op);
    logic [W-1:0] b_eff;
    b_eff = (op == OP_ADD) ? b : ~b;
    return {1'b0, a} + {1'b0, b_eff} + (W+1)'(op);
  endfunction

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
    return (int'(id) == NREQ - 1) ? '0 : id + 1'b1;
  endfunction

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr;
  logic            pick_any;
  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_idx;
  logic            accept, retire;
  logic [W-1:0]    a_sel, b_sel;
  logic            op_sel;
  logic [W-1:0]    a_p0, b_p0;
  logic            op_p0;
  logic [IDW-1:0]  id_p0;
  logic [W:0]      sum_p1;

  yarvis_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req (bus.req_valid),
    .ptr (ptr),
    .any (pick_any),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    op_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) begin
        a_sel  = bus.req_a[i*W +: W];
        b_sel  = bus.req_b[i*W +: W];
        op_sel = bus.req_op[i];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    accept        = 1'b0;
    retire        = 1'b0;
    unique case (state)
      IDLE: if (!rst && pick_any) begin
        bus.req_ready = pick_gnt;
        accept        = 1'b1;
        state_nxt     = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: if (bus.rsp_ready) begin
        retire    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // p0: operands captured at grant
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0  <= a_sel;
      b_p0  <= b_sel;
      op_p0 <= op_sel;
    end
  end

  // p1: result registered in EXEC, held through RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      id_p0  <= '0;
      sum_p1 <= '0;
    end else begin
      if (accept)         id_p0  <= pick_idx;
      if (state == EXEC)  sum_p1 <= add_sub(a_p0, b_p0, op_p0);
      if (retire)         ptr    <= next_ptr(id_p0);
    end
  end

  assign bus.rsp_valid = (state == RESP);
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_id    = id_p0;
  assign bus.rsp_data  = sum_p1[W-1:0];
  assign bus.rsp_carry = sum_p1[W];
endmodule

// File: tb/tb_yarvis_alu_arbiter.sv
// Directed bench for yarvis_alu_arbiter: ADD/SUB results, round-robin order, backpressure and reset.
module tb_yarvis_alu_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  yarvis_alu_arbiter_if #(.W(8), .NREQ(4), .IDW(2)) bus ();

  yarvis_alu_arbiter #(.W(8), .NREQ(4), .IDW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic op);
    bus.req_valid[i]      = 1'b1;
    bus.req_a[i*8 +: 8]   = a;
    bus.req_b[i*8 +: 8]   = b;
    bus.req_op[i]         = op;
  endtask

  task automatic clr_req(input int i);
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic do_op(input string tag, input int i, input logic [7:0] a, input logic [7:0] b,
                       input logic op, input logic [3:0] exp_gnt, input logic [7:0] exp_data,
                       input logic exp_carry);
    set_req(i, a, b, op);
    #1;
    chk({tag, "_grant"}, 32'(bus.req_ready), 32'(exp_gnt));
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    step();
    clr_req(i);
    chk({tag, "_exec_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "_exec_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_exec_valid"}, 32'(bus.rsp_valid), 32'd0);
    step();
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'(i));
    chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(exp_data));
    chk({tag, "_rsp_carry"}, 32'(bus.rsp_carry), 32'(exp_carry));
    step();
    chk({tag, "_back_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;
    step();
    step();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_rsp_carry", 32'(bus.rsp_carry), 32'd0);
    rst = 1'b0;
    step();

    // Single ADD and SUB with/without borrow (ptr 0 -> 2 -> 3 -> 3)
    do_op("add", 1, 8'hF0, 8'h20, 1'b0, 4'b0010, 8'h10, 1'b1);
    do_op("sub_borrow", 2, 8'h05, 8'h07, 1'b1, 4'b0100, 8'hFE, 1'b0);
    do_op("sub_noborrow", 2, 8'h07, 8'h05, 1'b1, 4'b0100, 8'h02, 1'b1);

    // Pointer wrap: ptr = 3, requesters 0 and 3 pending
    set_req(0, 8'h0C, 8'h03, 1'b0);
    set_req(3, 8'hFF, 8'h01, 1'b0);
    #1;
    chk("wrap_grant3", 32'(bus.req_ready), 32'b1000);
    step();
    clr_req(3);
    chk("wrap_exec_ready", 32'(bus.req_ready), 32'd0);
    step();
    chk("wrap_rsp_id3", 32'(bus.rsp_id), 32'd3);
    chk("wrap_rsp_data3", 32'(bus.rsp_data), 32'h00);
    chk("wrap_rsp_carry3", 32'(bus.rsp_carry), 32'd1);
    step();
    chk("wrap_grant0", 32'(bus.req_ready), 32'b0001);
    step();
    clr_req(0);
    step();
    chk("wrap_rsp_id0", 32'(bus.rsp_id), 32'd0);
    chk("wrap_rsp_data0", 32'(bus.rsp_data), 32'h0F);
    chk("wrap_rsp_carry0", 32'(bus.rsp_carry), 32'd0);
    step();

    // Backpressure with ptr = 1; requesters 2 and 3 queue up during the stall
    bus.rsp_ready = 1'b0;
    set_req(0, 8'h33, 8'h44, 1'b0);
    #1;
    chk("bp_grant0", 32'(bus.req_ready), 32'b0001);
    step();
    clr_req(0);
    set_req(2, 8'h10, 8'h01, 1'b1);
    set_req(3, 8'h80, 8'h80, 1'b0);
    #1;
    chk("bp_exec_ready", 32'(bus.req_ready), 32'd0);
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_hold_id", 32'(bus.rsp_id), 32'd0);
      chk("bp_hold_data", 32'(bus.rsp_data), 32'h77);
      chk("bp_hold_ready", 32'(bus.req_ready), 32'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_valid", 32'(bus.rsp_valid), 32'd1);
    step();
    chk("bp_idle_busy", 32'(bus.busy), 32'd0);
    chk("bp_next_grant2", 32'(bus.req_ready), 32'b0100);
    step();
    clr_req(2);
    step();
    chk("bp_rsp_id2", 32'(bus.rsp_id), 32'd2);
    chk("bp_rsp_data2", 32'(bus.rsp_data), 32'h0F);
    chk("bp_rsp_carry2", 32'(bus.rsp_carry), 32'd1);
    step();
    chk("bp_next_grant3", 32'(bus.req_ready), 32'b1000);
    step();
    clr_req(3);
    step();
    chk("bp_rsp_id3", 32'(bus.rsp_id), 32'd3);
    chk("bp_rsp_data3", 32'(bus.rsp_data), 32'h00);
    chk("bp_rsp_carry3", 32'(bus.rsp_carry), 32'd1);
    step();

    // Reset mid-operation: move ptr to 2, start an op, reset in EXEC
    do_op("pre_rst", 1, 8'h01, 8'h01, 1'b0, 4'b0010, 8'h02, 1'b0);
    set_req(3, 8'hAA, 8'h55, 1'b0);
    #1;
    chk("mid_grant3", 32'(bus.req_ready), 32'b1000);
    step();
    clr_req(3);
    chk("mid_exec_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_data", 32'(bus.rsp_data), 32'd0);
    step();
    chk("mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
    set_req(1, 8'h11, 8'h22, 1'b0);
    set_req(3, 8'h33, 8'h44, 1'b0);
    #1;
    chk("mid_ptr0_grant1", 32'(bus.req_ready), 32'b0010);
    step();
    clr_req(1);
    clr_req(3);
    step();
    chk("mid_rsp_id", 32'(bus.rsp_id), 32'd1);
    chk("mid_rsp_data", 32'(bus.rsp_data), 32'h33);
    step();

    // Fairness: all four held from reset
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 8'(i * 17), 8'h01, 1'b0);
    #1;
    chk("fair_rst_ready", 32'(bus.req_ready), 32'd0);
    step();
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      #1;
      chk("fair_grant", 32'(bus.req_ready), 32'(1 << (n % 4)));
      step();
      chk("fair_exec_busy", 32'(bus.busy), 32'd1);
      step();
      chk("fair_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("fair_rsp_id", 32'(bus.rsp_id), 32'(n % 4));
      chk("fair_rsp_data", 32'(bus.rsp_data), 32'(((n % 4) * 17 + 1) & 8'hFF));
      step();
    end
    bus.req_valid = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
